// File: rtl/array_15_port_ctrl.sv
// ---------------------------------------------------------------------------
// array_15_port_ctrl
//   Request-side controller for the 512x84 single-port array_15_ext macro
//   (RW0 port, 1-cycle read latency). It issues at most one macro access per
//   cycle. Read data is captured in a response FIFO so the consumer can apply
//   backpressure.
//
// Optional feature, enabled by defining ARRAY15_CTRL_INIT_EN:
//   After reset the array is swept with zero writes (addresses 0..511, one
//   per cycle) before any request is accepted.
//
// Parameters
//   RESP_DEPTH  response FIFO entries (2..8); also the outstanding-read credit
//
// Ports
//   clock, reset            clock and asynchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_write, req_addr     request kind (1 = write) and array index
//   req_mask, req_wdata     write lane enables (lane i = bits [i*21 +: 21]), data
//   resp_valid/resp_ready   response handshake
//   resp_rdata              oldest read data
//   init_done               controller is in RUN
//   RW0_*                   macro port (en, addr, wmode, wmask, wdata, rdata)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid, once raised, is expected to hold with stable payload
// until the transfer; ready never depends combinationally on the same
// interface's valid or payload.
// ---------------------------------------------------------------------------
module array_15_port_ctrl #(
  parameter int RESP_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [8:0]  req_addr,
  input  logic [3:0]  req_mask,
  input  logic [83:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [83:0] resp_rdata,
  output logic        init_done,
  output logic        RW0_en,
  output logic [8:0]  RW0_addr,
  output logic        RW0_wmode,
  output logic [3:0]  RW0_wmask,
  output logic [83:0] RW0_wdata,
  input  logic [83:0] RW0_rdata
);

  localparam int OCC_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RESP_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(RESP_DEPTH);
  localparam logic [OCC_W:0]   CREDIT_LIM = (OCC_W + 1)'(RESP_DEPTH);

  logic             fire;
  logic             push;
  logic             pop;
  logic             inflight;
  logic             inflight_next;
  logic             ready_q;
  logic             init_done_next;
  logic             credit_next;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [83:0]      fifo_mem [RESP_DEPTH];

  // Pointers wrap modulo RESP_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign fire          = req_valid && req_ready;
  assign inflight_next = fire && !req_write;
  assign push          = inflight;
  assign pop           = resp_valid && resp_ready;
  assign resp_valid    = (occ != '0);
  assign resp_rdata    = fifo_mem[head];

  // req_ready is a flop loaded with next cycle's credit check, so it is
  // purely registered and reads 0 while reset is held.
  assign req_ready = ready_q;

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  // Writes are held off too when credits run out; one shared ready keeps
  // the request side simple.
  assign credit_next = (({1'b0, occ_next} + {{OCC_W{1'b0}}, inflight_next}) < CREDIT_LIM);

`ifdef ARRAY15_CTRL_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t     state;
  state_t     state_next;
  logic [8:0] init_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_addr <= init_addr + 9'd1;
    end
  end

  assign init_done      = (state == ST_RUN);
  assign init_done_next = (state_next == ST_RUN);
`else
  assign init_done      = 1'b1;
  assign init_done_next = 1'b1;
`endif

  // Next-state and macro port drive.
  always_comb begin
    RW0_en    = fire;
    RW0_addr  = req_addr;
    RW0_wmode = req_write;
    RW0_wmask = req_write ? req_mask : 4'h0;
    RW0_wdata = req_wdata;
`ifdef ARRAY15_CTRL_INIT_EN
    state_next = state;
    if (state == ST_INIT) begin
      if (init_addr == 9'h1FF) state_next = ST_RUN;
      // Gated by reset so the sweep write does not hit the macro while
      // reset is still held.
      RW0_en    = !reset;
      RW0_addr  = init_addr;
      RW0_wmode = 1'b1;
      RW0_wmask = 4'hF;
      RW0_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q  <= 1'b0;
      inflight <= 1'b0;
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      ready_q  <= init_done_next && credit_next;
      inflight <= inflight_next;
      occ      <= occ_next;
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
    end
  end

  // Data storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[tail] <= RW0_rdata;
  end

  // The credit rule must never let a read land in a full FIFO.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    push |-> (occ != OCC_FULL));

endmodule

// File: tb/tb_array_15_port_ctrl.sv
`timescale 1ns/1ps
module tb_array_15_port_ctrl;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [3:0]  req_mask = '0;
  logic [83:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [83:0] resp_rdata;
  logic        init_done;
  logic        RW0_en;
  logic [8:0]  RW0_addr;
  logic        RW0_wmode;
  logic [3:0]  RW0_wmask;
  logic [83:0] RW0_wdata;
  logic [83:0] RW0_rdata;

  always #5 clock = ~clock;

`ifdef ARRAY15_CTRL_INIT_EN
  localparam int   READY_CYC = 512;
  localparam logic INIT0     = 1'b0;
`else
  localparam int   READY_CYC = 1;
  localparam logic INIT0     = 1'b1;
`endif

  array_15_port_ctrl #(.RESP_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .RW0_en(RW0_en), .RW0_addr(RW0_addr), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  // ---------------- macro model: 512x84, 1-cycle read ----------------
  logic [83:0] mem [512];
  logic        preload = 1'b1;

  always @(posedge clock) begin
    if (preload) begin
      mem[0]   <= '1;
      mem[511] <= '1;
    end else if (RW0_en) begin
      if (RW0_wmode) begin
        for (int i = 0; i < 4; i++)
          if (RW0_wmask[i]) mem[RW0_addr][i*21 +: 21] <= RW0_wdata[i*21 +: 21];
      end else begin
        RW0_rdata <= mem[RW0_addr];
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          passed = 0;
  logic [83:0] exp_q[$];
  logic [83:0] exp_d;
  logic [8:0]  rd_addr = 9'h010;

  function automatic logic [83:0] data_for(input logic [8:0] a);
    logic [31:0] h;
    h = 32'h9E3779B1 * {23'd0, a};
    return {3'b101, a, h, ~h, 8'hC3};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [8:0] a, input logic [3:0] m,
                       input logic [83:0] d);
    int w;
    w = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_mask = m; req_wdata = d;
    while (!req_ready && w < 1000) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (!req_ready) $display("FAIL issue_timeout got req_ready=%b want 1 (addr %h)", req_ready, a);
    else passed++;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic pop_one();
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic release_reset(output int cyc);
    reset = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 600) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Streams reads from rd_addr; pops are checked in order against exp_q.
  task automatic run_reads(input int cycles, input logic valid,
                           output int fires, output int pops);
    fires = 0;
    pops  = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      req_valid = valid; req_write = 1'b0; req_addr = rd_addr;
      req_mask = '0; req_wdata = '0;
      if (resp_valid && resp_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL resp_unexpected got %h want no response", resp_rdata);
        end else begin
          exp_d = exp_q.pop_front();
          if (resp_rdata !== exp_d) $display("FAIL resp_order got %h want %h", resp_rdata, exp_d);
          else passed++;
        end
      end
      if (req_valid && req_ready) begin
        fires++;
        exp_q.push_back(data_for(rd_addr));
        rd_addr++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    @(posedge clock); #1;
    preload = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %b want 0", req_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else passed++;
    checks++; if (RW0_en !== 1'b0) $display("FAIL reset_rw0_en got %b want 0", RW0_en); else passed++;
    checks++; if (init_done !== INIT0) $display("FAIL reset_init_done got %b want %b", init_done, INIT0); else passed++;
    release_reset(cyc);
    checks++; if (cyc != READY_CYC) $display("FAIL ready_after_reset got %0d cycles want %0d", cyc, READY_CYC); else passed++;
    checks++; if (init_done !== 1'b1) $display("FAIL init_done_run got %b want 1", init_done); else passed++;
  endtask

`ifdef ARRAY15_CTRL_INIT_EN
  task automatic test_init();
    issue(1'b0, 9'h000, 4'h0, '0);
    issue(1'b0, 9'h1FF, 4'h0, '0);
    @(negedge clock);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 84'h0) $display("FAIL init_zero_0 got v=%b %h want v=1 0", resp_valid, resp_rdata); else passed++;
    pop_one();
    @(negedge clock);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 84'h0) $display("FAIL init_zero_1ff got v=%b %h want v=1 0", resp_valid, resp_rdata); else passed++;
    pop_one();
  endtask
`endif

  task automatic test_write_read();
    logic [83:0] d;
    int extra;
    d = 84'h1_2345_6789_ABCD_EF01_2345;
    issue(1'b1, 9'h005, 4'hF, d);
    issue(1'b0, 9'h005, 4'h0, '0);
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0) $display("FAIL rd_latency_n1 got %b want 0", resp_valid); else passed++;
    @(negedge clock);
    checks++; if (resp_valid !== 1'b1) $display("FAIL rd_latency_n2 got %b want 1", resp_valid); else passed++;
    checks++; if (resp_rdata !== d) $display("FAIL rd_data got %h want %h", resp_rdata, d); else passed++;
    pop_one();
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (resp_valid) extra++;
    end
    checks++; if (extra != 0) $display("FAIL rd_single_resp got %0d extra want 0", extra); else passed++;
  endtask

  task automatic test_mask();
    logic [83:0] d2, e;
    d2 = 84'h2_4681_3579_BDF0_ACE1_2468;
    e  = {21'h1FFFFF, d2[62:42], 21'h1FFFFF, d2[20:0]};
    issue(1'b1, 9'h1FF, 4'hF, '1);
    issue(1'b1, 9'h1FF, 4'b0101, d2);
    issue(1'b0, 9'h1FF, 4'h0, '0);
    repeat (2) @(negedge clock);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== e) $display("FAIL mask_merge got v=%b %h want v=1 %h", resp_valid, resp_rdata, e); else passed++;
    pop_one();
  endtask

  task automatic test_macro_port();
    logic [83:0] d3;
    d3 = 84'h3_0F0F_1E1E_2D2D_3C3C_4B4B;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h1F0; req_mask = 4'hF; req_wdata = d3;
    #1;
    checks++; if (RW0_en !== 1'b1 || RW0_wmode !== 1'b0 || RW0_wmask !== 4'h0 || RW0_addr !== 9'h1F0)
      $display("FAIL port_read got en=%b wm=%b mask=%h addr=%h want 1 0 0 1f0", RW0_en, RW0_wmode, RW0_wmask, RW0_addr);
    else passed++;
    req_write = 1'b1; req_mask = 4'hA;
    #1;
    checks++; if (RW0_wmode !== 1'b1 || RW0_wmask !== 4'hA || RW0_wdata !== d3)
      $display("FAIL port_write got wm=%b mask=%h data=%h want 1 a %h", RW0_wmode, RW0_wmask, RW0_wdata, d3);
    else passed++;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    checks++; if (RW0_en !== 1'b0) $display("FAIL port_idle_en got %b want 0", RW0_en); else passed++;
  endtask

  task automatic prewrite();
    for (int a = 16; a < 80; a++) issue(1'b1, 9'(a), 4'hF, data_for(9'(a)));
    rd_addr = 9'h010;
  endtask

  task automatic test_backpressure();
    int f, p;
    resp_ready = 1'b0;
    run_reads(10, 1'b1, f, p);
    checks++; if (f != 4) $display("FAIL bp_accepted got %0d want 4", f); else passed++;
    checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready_low got %b want 0", req_ready); else passed++;
    @(posedge clock); #1;
    resp_ready = 1'b1;
    run_reads(4, 1'b1, f, p);
    checks++; if (p != 4) $display("FAIL bp_release_pops got %0d want 4", p); else passed++;
    checks++; if (f != 3) $display("FAIL bp_release_fires got %0d want 3", f); else passed++;
  endtask

  task automatic test_back_to_back();
    int f, p;
    run_reads(20, 1'b1, f, p);
    checks++; if (f != 20) $display("FAIL stream_fires got %0d want 20", f); else passed++;
    checks++; if (p != 20) $display("FAIL stream_pops got %0d want 20", p); else passed++;
    run_reads(8, 1'b0, f, p);
    checks++; if (p != 3) $display("FAIL drain_pops got %0d want 3", p); else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL drain_left got %0d want 0", exp_q.size()); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", resp_valid); else passed++;
  endtask

  task automatic test_reset_flush();
    int f, p, cyc, stale;
    resp_ready = 1'b0;
    run_reads(3, 1'b1, f, p);
    checks++; if (f != 3) $display("FAIL flush_setup_fires got %0d want 3", f); else passed++;
    @(posedge clock); #1;
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1) $display("FAIL flush_setup_valid got %b want 1", resp_valid); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0) $display("FAIL flush_resp_valid got %b want 0", resp_valid); else passed++;
    checks++; if (req_ready !== 1'b0) $display("FAIL flush_req_ready got %b want 0", req_ready); else passed++;
    repeat (2) @(posedge clock);
    @(negedge clock);
    exp_q.delete();
    release_reset(cyc);
    checks++; if (cyc != READY_CYC) $display("FAIL flush_ready_cyc got %0d want %0d", cyc, READY_CYC); else passed++;
    resp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (resp_valid) stale++;
    end
    checks++; if (stale != 0) $display("FAIL flush_stale got %0d responses want 0", stale); else passed++;
    resp_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
`ifdef ARRAY15_CTRL_INIT_EN
    test_init();
`endif
    test_write_read();
    test_mask();
    test_macro_port();
    prewrite();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
